// File: rtl/kpn_sched_pkg.sv
// kpn_sched_pkg
// Shared definitions for the KPN tick scheduler: FSM state encoding, the
// minimum legal divide ratio and the default divide ratio loaded at reset.
// No ports (package).

package kpn_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        GRANT = 2'd2
    } state_t;

    // A ratio of 2 leaves at least one non-tick cycle between ticks, which is
    // the slot the single-cycle GRANT state occupies.
    localparam int MIN_DIV = 2;

    // 1 tick per second from a 50 MHz clock.
    localparam int DEFAULT_DIV_RATIO = 50_000_000;

    // Clamp a divide ratio to the legal minimum.
    function automatic int clamp_div(input int ratio);
        return (ratio < MIN_DIV) ? MIN_DIV : ratio;
    endfunction

endpackage

// File: rtl/kpn_tick_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin priority select. The winner is the first set
// request bit found searching upward from rr_ptr, wrapping past the top.
// Ports:
//   req        in   NUM_REQ  request vector
//   rr_ptr     in   IDX_W    search start index
//   win_onehot out  NUM_REQ  one-hot winner (all zero when req == 0)
//   win_idx    out  IDX_W    winner index (0 when req == 0)

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx
);

    logic found;
    int   cand;

    always_comb begin
        found      = 1'b0;
        cand       = 0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
        if (found) begin
            win_onehot = NUM_REQ'(1) << win_idx;
        end
    end

endmodule

// File: rtl/kpn_tick_scheduler.sv
// kpn_tick_scheduler
// One programmable clock divider shared by NUM_REQ KPN processes. Each
// terminal count produces a tick; if any process is requesting on that tick,
// a round-robin winner is captured and granted a one-cycle fire enable in
// the following cycle.
// Ports:
//   clk_in        in   1        system clock
//   reset         in   1        asynchronous active-high reset
//   run           in   1        1 = divider counts, 0 = divider held at 0
//   cfg_wr        in   1        strobe: load cfg_div (clamped to >= 2)
//   cfg_div       in   CNT_W    new divide ratio
//   req           in   NUM_REQ  request levels, held by each process until granted
//   tick          out  1        one-cycle pulse at terminal count
//   clk_out       out  1        toggles on every tick
//   grant         out  NUM_REQ  one-hot, one-cycle fire enable
//   grant_id      out  IDX_W    index of the last captured winner
//   conflict_cnt  out  SAT_W    saturating count of ticks with >1 request
//   busy          out  1        state != IDLE
//   fsm_state     out  2        raw FSM state for observation
//
// Protocol: there is no back-pressure. req is a level sampled only in a tick
// cycle; grant is a one-cycle pulse exactly one cycle after that tick and the
// granted process is expected to drop its req bit after seeing it.

module kpn_tick_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = kpn_sched_pkg::DEFAULT_DIV_RATIO,
    parameter int SAT_W       = 8
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       cfg_wr,
    input  logic [CNT_W-1:0]           cfg_div,
    input  logic [NUM_REQ-1:0]         req,
    output logic                       tick,
    output logic                       clk_out,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [SAT_W-1:0]           conflict_cnt,
    output logic                       busy,
    output logic [1:0]                 fsm_state
);

    import kpn_sched_pkg::*;

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int RST_DIV = clamp_div(DEFAULT_DIV);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   div_reg;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant_hold;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_idx;
    logic               terminal;
    logic               tick_c;
    logic               capture;
    logic               multi_req;
    logic [IDX_W-1:0]   ptr_after_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx)
    );

    assign terminal  = (counter == div_reg - CNT_W'(1));
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_req = ((req & (req - NUM_REQ'(1))) != '0);

    assign ptr_after_grant = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0
                                                                : grant_id + IDX_W'(1);

    // Next-state, next-count and tick decode.
    always_comb begin
        state_next = state;
        cnt_next   = counter;
        tick_c     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (run) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                // A terminal count still ticks when run drops in the same
                // cycle; a config write in that cycle suppresses it.
                if (terminal && !cfg_wr) begin
                    tick_c   = 1'b1;
                    cnt_next = '0;
                    if (req != '0) begin
                        capture    = 1'b1;
                        state_next = GRANT;
                    end else if (!run) begin
                        state_next = IDLE;
                    end
                end else if (!run) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = counter + CNT_W'(1);
                end
            end
            GRANT: begin
                // The captured grant is issued regardless of run; run only
                // decides where we go afterwards.
                if (run) begin
                    cnt_next   = counter + CNT_W'(1);
                    state_next = COUNT;
                end else begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
        if (cfg_wr) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            counter      <= '0;
            div_reg      <= CNT_W'(RST_DIV);
            rr_ptr       <= '0;
            grant_hold   <= '0;
            grant_id     <= '0;
            clk_out      <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            counter <= cnt_next;
            if (cfg_wr) begin
                div_reg <= (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;
            end
            if (tick_c) begin
                clk_out <= ~clk_out;
                if (multi_req && (conflict_cnt != '1)) begin
                    conflict_cnt <= conflict_cnt + SAT_W'(1);
                end
            end
            if (capture) begin
                grant_hold <= arb_onehot;
                grant_id   <= arb_idx;
            end
            if (state == GRANT) begin
                rr_ptr <= ptr_after_grant;
            end
        end
    end

    // Outputs decoded from state so an asynchronous reset removes a grant
    // in the same instant.
    assign tick      = tick_c;
    assign grant     = (state == GRANT) ? grant_hold : '0;
    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: doc/kpn_tick_scheduler.md
Name: kpn_tick_scheduler

Overview:
- Shares one programmable clock-divider counter among NUM_REQ KPN process modules.
- Each divider terminal count produces one "fire" slot. A round-robin arbiter grants that slot to a requesting process as a single-cycle enable.
- Software program logic sets the rate at runtime through a config write.
- Replaces per-process dividers with one sequenced, shared time base.

Parameters:
- NUM_REQ, 4, number of requesting processes (2..16).
- CNT_W, 27, divider counter width in bits.
- DEFAULT_DIV, 50_000_000, divide ratio loaded at reset (1 tick/s at 50 MHz).
- SAT_W, 8, width of the saturating conflict counter.

Ports:
- clk_in  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = divider counts, 0 = divider held.
- cfg_wr  input  1  single-cycle strobe; loads cfg_div.
- cfg_div  input  CNT_W  new divide ratio.
- req  input  NUM_REQ  per-process request level, held until granted.
- tick  output  1  one-cycle pulse at divider terminal count.
- clk_out  output  1  square wave; toggles on every tick.
- grant  output  NUM_REQ  one-hot, one-cycle fire enable.
- grant_id  output  $clog2(NUM_REQ)  index of the last grant.
- conflict_cnt  output  SAT_W  saturating count of ticks with more than one request pending.
- busy  output  1  high when the FSM is not IDLE.

Behaviour:
- Clock and reset: single clock domain, clk_in, posedge. Asynchronous, active-high reset.
- Reset values:
  - div_reg = DEFAULT_DIV (clamped to at least 2).
  - counter = 0, rr_ptr = 0.
  - tick, clk_out, grant, grant_id, conflict_cnt and busy all 0.
  - state = IDLE.
- FSM states IDLE, COUNT, GRANT:
  - IDLE: counter held at 0. Enter COUNT when run=1.
  - COUNT: counter increments by 1 each cycle.
    - When counter == div_reg-1: counter <= 0, tick=1 that cycle, clk_out toggles.
    - If that tick sees req != 0, capture the round-robin winner and go to GRANT. Otherwise stay in COUNT.
    - run=0 in COUNT: go to IDLE and clear the counter.
  - GRANT (exactly 1 cycle):
    - grant[winner]=1, grant_id=winner, rr_ptr <= winner+1 (mod NUM_REQ).
    - Counter keeps incrementing.
    - Next state is COUNT if run=1, else IDLE.
    - A grant already captured is always issued, even if run has dropped.
- Latency: grant is asserted exactly 1 cycle after the tick that selected it.
- Arbitration:
  - Winner = first set req bit searching upward from rr_ptr, wrapping around.
  - req is sampled only in the tick cycle.
  - Requests raised between ticks wait for the next tick.
  - A tick with req == 0 issues no grant and leaves rr_ptr unchanged.
- conflict_cnt: +1 on any tick where popcount(req) > 1. Saturates at 2^SAT_W-1 and never wraps.
- Config write:
  - cfg_wr=1 loads div_reg <= max(cfg_div, 2) and clears the counter to 0 that cycle.
  - No tick is generated in a write cycle.
  - The next tick comes div_reg cycles later.
  - cfg_wr in the GRANT cycle: the grant is still issued.
  - Simultaneous terminal count and cfg_wr: the write wins and the tick is suppressed.
- Minimum div_reg=2 guarantees at least 1 non-tick cycle between ticks, so GRANT never overlaps a following tick.
- busy = (state != IDLE).
- Reset mid-GRANT: grant drops immediately (asynchronous) and no pending state is kept.

Decomposition:
- Package kpn_sched_pkg: state enum (IDLE, COUNT, GRANT), MIN_DIV=2, DEFAULT_DIV.
- Sub-module rr_arbiter: combinational round-robin priority select over NUM_REQ, taking req and rr_ptr, producing a one-hot winner and its index.
- Counter, FSM and conflict counter live in the top module.

Test Plan:
- Reset, then cfg_div=4, run=1, req=0 -> tick every 4 cycles, clk_out period 8 cycles, grant stays 0, rr_ptr stays 0.
- div=4, req=4'b1111 held for 8 ticks -> grants in order 0,1,2,3,0,1,2,3, each 1 cycle after its tick; conflict_cnt=8.
- div=4, req=4'b1010 with rr_ptr=0 -> grants 1,3,1. With req=4'b0001 raised mid-interval, grant 0 follows the next tick only.
- div=10, cfg_wr with cfg_div=1 at counter=5 -> counter cleared, div_reg=2, next tick 2 cycles later, then every 2 cycles. Write coincident with a terminal count -> no tick that cycle.
- run dropped in the tick cycle with req=4'b0100 -> grant[2] still pulses the next cycle, then IDLE, busy=0, no further ticks. run reasserted -> first tick div_reg cycles later.
- 300 ticks with req=4'b0011 -> conflict_cnt saturates at 255. reset asserted during GRANT -> grant=0 immediately and all outputs return to reset values.
